// File: rtl/dcache_mem_subsystem.sv
// ----------------------------------------------------------------------------
// dcache_mem_subsystem
//
// Purpose:
//   CPU-side data memory subsystem. It is a direct-mapped, write-back byte
//   cache with 8 lines of 32-bit blocks. A 64 x 32-bit backing memory sits
//   behind it. On a miss the CPU is stalled through busywait while the
//   controller does two things: it writes back the old block if that block
//   is dirty, and it fetches the new block.
//
// Parameters:
//   MEM_LATENCY  clock cycles per backing-memory block read or block write
//
// Ports:
//   CLK        in   1  single clock, all state updates on the rising edge
//   RESET      in   1  synchronous, active-high reset
//   read       in   1  CPU load request, held until busywait is low
//   write      in   1  CPU store request, held until busywait is low (wins over read)
//   address    in   8  byte address: tag=[7:5], index=[4:2], offset=[1:0]
//   writedata  in   8  store data
//   readdata   out  8  load data (valid in IDLE on a read hit, else 0)
//   busywait   out  1  high = CPU must stall and hold its request stable
// ----------------------------------------------------------------------------
module dcache_mem_subsystem #(
    parameter int MEM_LATENCY = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       busywait
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_WRITE,
        MEM_READ,
        UPDATE
    } state_t;

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Cache storage
    logic [31:0] line_data [8];
    logic [2:0]  line_tag  [8];
    logic [7:0]  line_valid;
    logic [7:0]  line_dirty;

    // Backing store, indexed by block address {tag, index}
    logic [31:0] mem [64];

    // Address fields
    logic [2:0] tag;
    logic [2:0] idx;
    logic [1:0] off;
    logic [4:0] bit_lo;
    logic       hit;
    logic       req;

    assign tag    = address[7:5];
    assign idx    = address[4:2];
    assign off    = address[1:0];
    assign bit_lo = {off, 3'b000};
    assign hit    = line_valid[idx] && (line_tag[idx] == tag);
    assign req    = read || write;

    // busywait and readdata are combinational so that a hit completes in
    // the cycle it is presented, with no stall.
    always_comb begin
        // NOTE: every output gets a default before any branch; without the
        // default, a path that skips the assignment would infer a latch.
        busywait = 1'b1;
        readdata = 8'h00;
        if (state == IDLE) begin
            busywait = req && !hit;
            if (read && !write && hit) begin
                readdata = line_data[idx][bit_lo +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples its old value at the edge, whatever the
            // statement order.
            state      <= IDLE;
            cnt        <= '0;
            line_valid <= '0;
            line_dirty <= '0;
            // NOTE: the backing memory is cleared on reset because loads
            // after reset must see zeros. That makes it a register file
            // rather than an inferred RAM macro.
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                line_data[i] <= '0;
                line_tag[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (write && hit) begin
                        line_data[idx][bit_lo +: 8] <= writedata;
                        line_dirty[idx]             <= 1'b1;
                    end else if (req && !hit) begin
                        cnt <= '0;
                        // A dirty victim must reach memory before its line is reused.
                        if (line_valid[idx] && line_dirty[idx]) begin
                            state <= MEM_WRITE;
                        end else begin
                            state <= MEM_READ;
                        end
                    end
                end

                MEM_WRITE: begin
                    if (cnt == CNT_LAST) begin
                        mem[{line_tag[idx], idx}] <= line_data[idx];
                        cnt   <= '0;
                        state <= MEM_READ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                MEM_READ: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= UPDATE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                UPDATE: begin
                    line_data[idx]  <= mem[{tag, idx}];
                    line_tag[idx]   <= tag;
                    line_valid[idx] <= 1'b1;
                    line_dirty[idx] <= 1'b0;
                    state           <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_mem_subsystem.sv
// ----------------------------------------------------------------------------
// tb_dcache_mem_subsystem
//
// Directed self-checking bench for dcache_mem_subsystem (MEM_LATENCY = 5).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// on the falling edge. The stall count of an access is the number of
// falling edges at which busywait was high before the request completed.
// ----------------------------------------------------------------------------
module tb_dcache_mem_subsystem;

    localparam int LAT       = 5;
    localparam int CLEAN     = LAT + 2;      // 7
    localparam int DIRTY     = 2 * LAT + 2;  // 12
    localparam int MAX_STALL = 50;

    logic       CLK;
    logic       RESET;
    logic       read;
    logic       write;
    logic [7:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       busywait;

    int n_checks;
    int n_fail;

    dcache_mem_subsystem #(.MEM_LATENCY(LAT)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Called and returns at posedge+1. Holds RESET for two edges with an
    // idle bus.
    task automatic apply_reset();
        RESET = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    // One CPU access, started at posedge+1 and ending at posedge+1 after the
    // completing edge. It checks the stall length and, for loads, the data.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input int exp_stall,
                          input logic chk_data, input logic [7:0] exp_data,
                          input string nm);
        int stall;
        read      = rd;
        write     = wr;
        address   = a;
        writedata = wd;
        stall     = 0;
        @(negedge CLK);
        while (busywait === 1'b1 && stall < MAX_STALL) begin
            stall++;
            @(negedge CLK);
        end
        n_checks++;
        if (stall !== exp_stall) begin
            n_fail++;
            $display("FAIL %s stall: got %0d cycles, expected %0d", nm, stall, exp_stall);
        end
        if (chk_data) begin
            n_checks++;
            if (readdata !== exp_data) begin
                n_fail++;
                $display("FAIL %s readdata: got %02h, expected %02h", nm, readdata, exp_data);
            end
        end
        @(posedge CLK);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (busywait !== 1'b0 || readdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_held: busywait=%b readdata=%02h, expected 0/00", busywait, readdata);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (busywait !== 1'b0 || readdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle: busywait=%b readdata=%02h, expected 0/00", busywait, readdata);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_clean_read_miss();
        apply_reset();
        access(1'b1, 1'b0, 8'h00, 8'h00, CLEAN, 1'b1, 8'h00, "read_miss_00");
        access(1'b1, 1'b0, 8'h00, 8'h00, 0,     1'b1, 8'h00, "read_hit_00");
    endtask

    task automatic test_write_miss();
        apply_reset();
        access(1'b0, 1'b1, 8'h01, 8'h05, CLEAN, 1'b0, 8'h00, "write_miss_01");
        access(1'b1, 1'b0, 8'h01, 8'h00, 0,     1'b1, 8'h05, "read_hit_01");
    endtask

    task automatic test_dirty_writeback();
        // Line 0 holds tag 0 dirty (0x05 at offset 1).
        access(1'b0, 1'b1, 8'h21, 8'hAA, DIRTY, 1'b0, 8'h00, "write_dirty_21");
        access(1'b1, 1'b0, 8'h21, 8'h00, 0,     1'b1, 8'hAA, "read_hit_21");
        access(1'b1, 1'b0, 8'h01, 8'h00, DIRTY, 1'b1, 8'h05, "read_back_01");
        // Line 0 is now clean tag 0; 0x21 must come back from memory.
        access(1'b1, 1'b0, 8'h21, 8'h00, CLEAN, 1'b1, 8'hAA, "read_mem_21");
    endtask

    task automatic test_offsets();
        logic [7:0] vals [4];
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        vals[3] = 8'h44;
        access(1'b1, 1'b0, 8'h08, 8'h00, CLEAN, 1'b1, 8'h00, "prime_08");
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b1, 8'h08 + 8'(i), vals[i], 0, 1'b0, 8'h00, "write_hit_off");
        end
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 1'b0, 8'h08 + 8'(i), 8'h00, 0, 1'b1, vals[i], "read_hit_off");
        end
    endtask

    task automatic test_read_write_together();
        // Line 0 holds clean tag 1, so 0x02 is a clean miss.
        access(1'b1, 1'b1, 8'h02, 8'h7E, CLEAN, 1'b0, 8'h00, "rw_together_02");
        access(1'b1, 1'b0, 8'h02, 8'h00, 0,     1'b1, 8'h7E, "read_after_rw_02");
    endtask

    task automatic test_reset_mid_writeback();
        // Line 0 holds dirty tag 0, so 0x21 starts a write-back.
        read      = 1'b0;
        write     = 1'b1;
        address   = 8'h21;
        writedata = 8'h99;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        write = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (busywait !== 1'b1) begin
            n_fail++;
            $display("FAIL in_mem_write busywait: got %b, expected 1", busywait);
        end
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (busywait !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busywait: got %b, expected 0", busywait);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        access(1'b1, 1'b0, 8'h21, 8'h00, CLEAN, 1'b1, 8'h00, "post_reset_21");
        access(1'b1, 1'b0, 8'h01, 8'h00, CLEAN, 1'b1, 8'h00, "post_reset_01");
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        RESET     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = 8'h00;
        writedata = 8'h00;
        @(posedge CLK);
        #1;
        test_reset();
        test_clean_read_miss();
        test_write_miss();
        test_dirty_writeback();
        test_offsets();
        test_read_write_together();
        test_reset_mid_writeback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
